// File: rtl/dsconv_block_depthwise_pe_pipelined.sv
// Depthwise-conv PE: KxK multiply, registered adder tree with bias leaf, requantise and saturate.
// Optional fused ReLU on the output when DSCONV_DW_PE_RELU_EN is defined.
module dsconv_block_depthwise_pe_pipelined #(
    parameter int DATA_W    = 18,
    parameter int K         = 7,
    parameter int FRAC_BITS = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [K*K*DATA_W-1:0]    x_flat,
    input  logic [K*K*DATA_W-1:0]    w_flat,
    input  logic [DATA_W-1:0]        bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_pixel
);

    localparam int N  = K * K;
    localparam int NL = N + 1;
    localparam int L  = $clog2(NL);
    localparam int PW = 2 * DATA_W;
    localparam int AW = PW + L;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic en;

    // The whole pipeline advances together; a held output freezes every stage.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    genvar lv;
    for (lv = 0; lv <= L; lv++) begin : g_lvl
        localparam int CNT = (NL + (1 << lv) - 1) >> lv;
        localparam int W   = PW + lv;

        logic signed [W-1:0] node [CNT];
        logic                vld;

        if (lv == 0) begin : g_leaf
            always_ff @(posedge clk) begin
                if (!rst) begin
                    node <= '{default: '0};
                    vld  <= 1'b0;
                end else if (en) begin
                    for (int t = 0; t < N; t++) begin
                        node[t] <= PW'($signed(x_flat[t*DATA_W +: DATA_W]))
                                 * PW'($signed(w_flat[t*DATA_W +: DATA_W]));
                    end
                    // Bias rides as the last leaf, aligned to the product's binary point.
                    node[N] <= PW'($signed(bias)) <<< FRAC_BITS;
                    vld     <= in_valid;
                end
            end
        end else begin : g_sum
            localparam int PCNT = (NL + (1 << (lv - 1)) - 1) >> (lv - 1);

            always_ff @(posedge clk) begin
                if (!rst) begin
                    node <= '{default: '0};
                    vld  <= 1'b0;
                end else if (en) begin
                    for (int j = 0; j < PCNT / 2; j++) begin
                        node[j] <= W'(g_lvl[lv-1].node[2*j]) + W'(g_lvl[lv-1].node[2*j+1]);
                    end
                    if (PCNT % 2 == 1) begin
                        node[CNT-1] <= W'(g_lvl[lv-1].node[PCNT-1]);
                    end
                    vld <= g_lvl[lv-1].vld;
                end
            end
        end
    end

    logic signed [AW-1:0]     acc;
    logic signed [AW-1:0]     shifted;
    logic signed [DATA_W-1:0] sat_val;
    logic signed [DATA_W-1:0] res;

    assign acc     = g_lvl[L].node[0];
    assign shifted = acc >>> FRAC_BITS;

    always_comb begin
        sat_val = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end
    end

`ifdef DSCONV_DW_PE_RELU_EN
    assign res = sat_val[DATA_W-1] ? '0 : sat_val;
`else
    assign res = sat_val;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
        end else if (en) begin
            out_valid <= g_lvl[L].vld;
            out_pixel <= res;
        end
    end

endmodule
